multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle control unit for the ARM core: a Moore FSM sequences shared PC/ALU/memory datapath through FETCH..WB steps.
//  Includes the instruction decode, ALU decode and condition logic with an NZCV flag register; gates all architectural writes by the condition.
//  Sits between the instruction register fields and datapath muxes/enables. Memory accesses stall on a ready handshake.
// PARAMETERS
//  MEM_HANDSHAKE  1        1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored, treated as 1
//  FLAG_RST       4'b0000  reset value of NZCV flag register {N,Z,C,V}
// PORTS
//  clk         in   1  clock, all state updates on rising edge
//  reset       in   1  asynchronous, active-low reset
//  op          in   2  Instr[27:26]
//  funct       in   6  Instr[25:20] ({I,cmd[3:0],S})
//  Rd          in   4  Instr[15:12]
//  Cond        in   4  Instr[31:28]
//  ALUFlags    in   4  {N,Z,C,V} from ALU, current cycle
//  mem_ready   in   1  memory has completed the current access
//  PCWrite     out  1  PC register enable
//  MemWrite    out  1  data memory write enable
//  RegWrite    out  1  register file write enable
//  IRWrite     out  1  instruction register enable
//  AdrSrc      out  1  0: PC, 1: ALUOut drives memory address
//  ALUSrcA     out  2  00 RegA, 01 PC
//  ALUSrcB     out  2  00 RegB, 01 ExtImm, 10 const 4
//  ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ImmSrc      out  2  = op
//  RegSrc      out  2  {op==01, op==10}
//  ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
//  illegal_op  out  1  one-cycle pulse in UNKNOWN state
//  state_o     out  4  current state encoding (debug)
// BEHAVIOUR
//  States (enc): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 EXECI7 ALUWB8 BRANCH9 UNKNOWN10.
//  Reset (reset=0, async): state=FETCH, flags=FLAG_RST, cond_q=0; outputs = FETCH decode (IRWrite/PCWrite=0 while reset asserted).
//  Transitions: FETCH->DECODE when ready. DECODE: op01->MEMADR; op00&!funct[5]->EXECR; op00&funct[5]->EXECI; op10->BRANCH; op11->UNKNOWN.
//   MEMADR: funct[0]?MEMRD:MEMWR. MEMRD->MEMWB when ready. MEMWR->FETCH when ready. EXECR/EXECI->ALUWB. MEMWB,ALUWB,BRANCH,UNKNOWN->FETCH.
//  ready = mem_ready | ~MEM_HANDSHAKE; unready FETCH/MEMRD/MEMWR hold state and all outputs.
//  Raw controls per state (others 0/00): FETCH AdrSrc0 A=01 B=10 Res=10 IRW=ready NextPC=ready; DECODE A=01 B=10 Res=10;
//   MEMADR A=00 B=01; MEMRD AdrSrc1 Res=00; MEMWB Res=01 RegW; MEMWR AdrSrc1 MemW; EXECR A=00 B=00 ALUOp;
//   EXECI A=00 B=01 ALUOp; ALUWB Res=00 RegW; BRANCH A=00 B=01 Res=10 Branch.
//  ALU decode (ALUOp=1, cmd=funct[4:1]): 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP=SUB+NoWrite; other cmd -> ADD.
//   ALUOp=0 -> ADD, FlagW=00. FlagW[1]=S; FlagW[0]=S & (ADD|SUB|CMP).
//  CondEx: combinational on Cond vs flags (EQ..LE standard ARM, 1110 AL=1, 1111 =0); cond_q latched on DECODE exit edge.
//  Flags: in EXECR/EXECI, FlagW[1]&cond_q -> NZ<=ALUFlags[3:2]; FlagW[0]&cond_q -> CV<=ALUFlags[1:0]. Same-cycle ALUFlags only.
//  PCS = (Rd==15)&RegW | Branch. Gated outputs: RegWrite=RegW&cond_q&~NoWrite_q; MemWrite=MemW&cond_q;
//   PCWrite=NextPC | PCS&cond_q. NoWrite_q latched in EXECR/EXECI for use in ALUWB.
//  FETCH/DECODE writes (IRWrite, NextPC) are unconditional; cond_q never affects the state sequence, only write enables.
//  Latency: DP 4 cycles, LDR 5, STR 4, B 3 (mem_ready=1). Reset mid-instruction aborts to FETCH, no partial write.
// TESTING
//  ADD R1,R2,R3 (op00 funct 001000 Cond1110), ready=1 -> states 0,1,6,8; RegWrite=1 only in ALUWB, ALUControl=00 in EXEC.
//  SUBS imm (funct 100101) with ALUFlags=0100 -> flags Z=1 after EXECI; next BEQ (op10 Cond0000) -> PCWrite=1 in BRANCH.
//  BNE with Z=1 -> 0,1,9,0; PCWrite=0 in BRANCH, RegWrite/MemWrite stay 0.
//  LDR (op01 funct[0]=1) with mem_ready low 3 cycles in MEMRD -> state holds 3, MEMWB only after ready, RegWrite one cycle.
//  STR with CondEx false -> MEMWR entered, MemWrite=0; CMP (cmd1010,S=1) -> flags updated, RegWrite=0 in ALUWB.
//  op=11 -> UNKNOWN, illegal_op 1-cycle pulse, back to FETCH; reset low during MEMWB -> async FETCH, flags=FLAG_RST.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM control unit: a Moore FSM steps the shared datapath through FETCH..WB, with
// instruction/ALU decode and an NZCV flag register whose condition result gates every architectural write.
module multicycle_ctrl_fsm #(
  parameter bit         MEM_HANDSHAKE = 1'b1,
  parameter logic [3:0] FLAG_RST      = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  state_t     state, state_n;
  logic [3:0] flags;
  logic       cond_q, nowrite_q;

  // Memory handshake: mem_ready high in FETCH/MEMRD/MEMWR means the access issued this cycle has
  // completed and the FSM may advance on this edge; while it is low the state and every output hold.
  logic ready;
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  logic       irw, next_pc, regw, memw, branch, alu_op;
  logic       cond_ex, no_write;
  logic [1:0] flag_w;
  logic [3:0] cmd;
  assign cmd = funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (ready) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_n = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_n = S_MEMADR;
          2'b10:   state_n = S_BRANCH;
          default: state_n = S_UNKNOWN;
        endcase
      end
      S_MEMADR: state_n = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_n = S_MEMWB;
      S_MEMWR:  if (ready) state_n = S_FETCH;
      S_EXECR,
      S_EXECI:  state_n = S_ALUWB;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    irw        = 1'b0;
    next_pc    = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = ready & reset;
        next_pc   = ready & reset;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    no_write   = 1'b0;
    if (alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: begin
          ALUControl = 2'b01;
          no_write   = 1'b1;
        end
        default: ALUControl = 2'b00;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010));
    end
  end

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // nowrite_q follows the EXEC decode each cycle, so it is valid in ALUWB and clear in MEMWB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= FLAG_RST;
      cond_q    <= 1'b0;
      nowrite_q <= 1'b0;
    end else begin
      if (state == S_DECODE) cond_q <= cond_ex;
      nowrite_q <= no_write;
      if ((state == S_EXECR) || (state == S_EXECI)) begin
        if (flag_w[1] & cond_q) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0] & cond_q) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  logic pcs;
  assign pcs        = ((Rd == 4'd15) & regw) | branch;
  assign RegWrite   = regw & cond_q & ~nowrite_q;
  assign MemWrite   = memw & cond_q;
  assign PCWrite    = next_pc | (pcs & cond_q);
  assign IRWrite    = irw;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign illegal_op = (state == S_UNKNOWN);
  assign state_o    = state;

endmodule
